conv_encoder: RTL and testbench
===============================

CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 SHALL have parameter TAIL_LEN, default 6, zero-tail bits appended per frame (equals K-1).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_bits  input  1  randomized data bit from the randomizer.
REQ-005 SHALL have port in_valid  input  1  in_bits valid this cycle.
REQ-006 SHALL have port in_last  input  1  qualifies in_bits as the final data bit of the frame.
REQ-007 SHALL have port in_ready  output  1  encoder accepts a bit this cycle.
REQ-008 SHALL have port out_bits  output  1  coded bit, serial order X then Y.
REQ-009 SHALL have port out_valid  output  1  out_bits valid this cycle.
REQ-010 SHALL have port out_last  output  1  marks the final coded bit of the frame.

Function
REQ-011 SHALL implement a rate-1/2, K=7 convolutional code: G1=171 octal -> X, G2=133 octal -> Y.
REQ-012 SHALL use 6-bit history s[5:0], s[0] newest; X = u^s0^s1^s2^s5, Y = u^s1^s2^s4^s5.
REQ-013 SHALL accept a bit on any rising edge where in_valid and in_ready are both 1; it then shifts u into s[0].
REQ-014 SHALL use states IDLE, SHOW_X, SHOW_Y, TAIL_X, TAIL_Y.
REQ-015 SHALL drive in_ready=1 only in IDLE and SHOW_Y.
REQ-016 SHALL, on accept, load X into out_bits and set out_valid=1 on the same edge: 1-cycle latency.
REQ-017 SHALL go SHOW_X -> SHOW_Y unconditionally, loading the stored Y.
REQ-018 SHALL, in SHOW_Y, go to SHOW_X on accept (gapless output), to TAIL_X if in_last was accepted, otherwise to IDLE with out_valid=0.
REQ-019 SHALL ignore in_valid while in SHOW_X or in the tail states; the upstream source holds its bit.
REQ-020 SHALL, after in_last, encode TAIL_LEN zero bits as TAIL_X/TAIL_Y pairs with a 3-bit tail counter, then return to IDLE.
REQ-021 SHALL assert out_last only with the final tail Y bit.
REQ-022 SHALL clear s[5:0] on return to IDLE after the tail, so each frame starts from the zero state.
REQ-023 SHALL treat in_last seen in IDLE as a one-bit frame: data pair followed by the tail.

Reset
REQ-024 SHALL force state=IDLE, s=0, out_bits=0, out_valid=0, out_last=0, tail counter=0 and puncture phase=0 on any edge with reset=1, including mid-frame; in-flight bits are discarded.
REQ-025 SHALL drive in_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-026 SHALL, with CONV_PUNCTURE_EN defined, add port rate_sel input 1 (0 = rate 1/2, 1 = rate 2/3), sampled at each frame's first accept and held for the whole frame.
REQ-027 SHALL, at rate 2/3, send X for even-phase bits only; odd-phase bits emit Y only. Accept goes straight to SHOW_Y, giving X1 Y1 Y2 per pair; tail bits are punctured the same way and the phase restarts at 0 each frame.
REQ-028 SHALL, without CONV_PUNCTURE_EN, have no rate_sel port and behave exactly at rate 1/2.

Structure
REQ-029 SHALL take G1, G2, K, TAIL_LEN defaults and state encodings from shared package conv_pkg.
REQ-030 SHALL place the X/Y parity computation in combinational sub-module conv_parity (u, s[5:0] -> X, Y).

Verification
REQ-031 SHALL check: reset, then 8 zero bits plus in_last -> 28 zero coded bits, out_last on the 28th.
REQ-032 SHALL check impulse: single bit 1 with in_last -> 11 10 11 11 00 01 11 (14 bits), out_last on the last.
REQ-033 SHALL check: in_valid held high for 4 bits -> in_ready pattern 1,0,1,0,...; out_valid continuous, no gaps.
REQ-034 SHALL check: reset asserted during TAIL_X -> next cycle out_valid=0, in_ready=1; a following frame of bit 1 reproduces REQ-032 output.
REQ-035 SHALL check, with CONV_PUNCTURE_EN and rate_sel=1: input 1,0 plus in_last -> X1=1,Y1=1,Y2=0 then punctured tail (9 bits), 12 bits total.

Source files
------------

// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg -- shared constants for the K=7, rate-1/2 convolutional encoder.
//
// Contents:
//   K, TAIL_LEN_DEF    constraint length and default zero-tail length (K-1)
//   G1, G2             generator polynomials (171 / 133 octal)
//   ST_*               FSM state encodings used by conv_encoder
//   conv_tap()         parity of one generator against (u, history)
// ---------------------------------------------------------------------------
package conv_pkg;

   localparam int K            = 7;
   localparam int TAIL_LEN_DEF = K - 1;

   localparam logic [6:0] G1 = 7'o171;
   localparam logic [6:0] G2 = 7'o133;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SHOW_X = 3'd1;
   localparam logic [2:0] ST_SHOW_Y = 3'd2;
   localparam logic [2:0] ST_TAIL_X = 3'd3;
   localparam logic [2:0] ST_TAIL_Y = 3'd4;

   // Generator MSB taps the incoming bit u, the next bit taps s[0] (newest),
   // down to the LSB which taps s[5] (oldest).
   function automatic logic conv_tap(input logic [6:0] g, input logic u,
                                     input logic [5:0] s);
      logic [6:0] reg_v;
      reg_v = {u, s[0], s[1], s[2], s[3], s[4], s[5]};
      return ^(g & reg_v);
   endfunction

endpackage

// File: rtl/conv_parity.sv
// ---------------------------------------------------------------------------
// conv_parity -- combinational X/Y parity for the K=7 convolutional code.
//
// Ports:
//   u   in   incoming bit
//   s   in   6-bit history, s[0] newest
//   x   out  G1 parity (u^s0^s1^s2^s5)
//   y   out  G2 parity (u^s1^s2^s4^s5)
// ---------------------------------------------------------------------------
module conv_parity
   import conv_pkg::*;
(
   input  logic       u,
   input  logic [5:0] s,
   output logic       x,
   output logic       y
);

   assign x = conv_tap(G1, u, s);
   assign y = conv_tap(G2, u, s);

endmodule

// File: rtl/conv_encoder.sv
// ---------------------------------------------------------------------------
// conv_encoder -- serial K=7 convolutional encoder (G1=171 -> X, G2=133 -> Y)
// with a zero tail of TAIL_LEN bits appended after the frame's last bit.
// Coded bits leave serially, X then Y, one cycle after the input accept.
//
// Optional feature: define CONV_PUNCTURE_EN to add port rate_sel
// (0 = rate 1/2, 1 = rate 2/3, captured at the frame's first accept).
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   in_bits    in   data bit
//   in_valid   in   in_bits valid
//   in_last    in   in_bits is the final data bit of the frame
//   rate_sel   in   (CONV_PUNCTURE_EN only) puncture select
//   in_ready   out  encoder takes a bit this cycle
//   out_bits   out  coded bit
//   out_valid  out  out_bits valid
//   out_last   out  final coded bit of the frame
// ---------------------------------------------------------------------------
module conv_encoder
   import conv_pkg::*;
#(
   parameter int TAIL_LEN = TAIL_LEN_DEF
)
(
   input  logic clk,
   input  logic reset,
   input  logic in_bits,
   input  logic in_valid,
   input  logic in_last,
`ifdef CONV_PUNCTURE_EN
   input  logic rate_sel,
`endif
   output logic in_ready,
   output logic out_bits,
   output logic out_valid,
   output logic out_last
);

   localparam logic [2:0] TAIL_LAST = 3'(TAIL_LEN);

   logic [2:0] state_r;
   logic [5:0] hist_r;
   logic       y_hold_r;
   logic       last_r;
   logic [2:0] tail_cnt_r;

   logic       accept_s;
   logic       load_tail_s;
   logic       load_bit_s;
   logic       u_s;
   logic       x_s;
   logic       y_s;
   logic       puncture_s;
   logic [2:0] tail_nxt_s;

   // Ready is withheld in SHOW_Y once in_last was taken: the tail starts there.
   assign in_ready    = (state_r == ST_IDLE) |
                        ((state_r == ST_SHOW_Y) & ~last_r);
   assign accept_s    = in_valid & in_ready;
   assign load_tail_s = ((state_r == ST_SHOW_Y) & last_r) |
                        ((state_r == ST_TAIL_Y) & (tail_cnt_r != TAIL_LAST));
   assign load_bit_s  = accept_s | load_tail_s;
   assign u_s         = accept_s ? in_bits : 1'b0;
   assign tail_nxt_s  = (state_r == ST_SHOW_Y) ? 3'd1 : (tail_cnt_r + 3'd1);

   conv_parity u_parity (
      .u (u_s),
      .s (hist_r),
      .x (x_s),
      .y (y_s)
   );

`ifdef CONV_PUNCTURE_EN
   logic phase_r;
   logic rate_r;
   logic in_frame_r;
   logic end_frame_s;

   // Phase is 0 at every frame's first bit, so a stale rate_r never punctures it.
   assign puncture_s  = rate_r & phase_r;
   assign end_frame_s = (state_r == ST_TAIL_Y) & (tail_cnt_r == TAIL_LAST);

   // Puncture phase and per-frame rate capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         phase_r    <= 1'b0;
         rate_r     <= 1'b0;
         in_frame_r <= 1'b0;
      end else if (end_frame_s) begin
         phase_r    <= 1'b0;
         in_frame_r <= 1'b0;
      end else if (load_bit_s) begin
         phase_r    <= ~phase_r;
         in_frame_r <= 1'b1;
         if (!in_frame_r) begin
            rate_r <= rate_sel;
         end
      end
   end
`else
   assign puncture_s = 1'b0;
`endif

   // Encoder FSM, history shift register and registered serial output.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         hist_r     <= 6'd0;
         y_hold_r   <= 1'b0;
         last_r     <= 1'b0;
         tail_cnt_r <= 3'd0;
         out_bits   <= 1'b0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
      end else if (load_bit_s) begin
         // New data or tail bit: present X now and park Y for the next cycle.
         hist_r    <= {hist_r[4:0], u_s};
         y_hold_r  <= y_s;
         last_r    <= accept_s & in_last;
         out_valid <= 1'b1;
         if (load_tail_s) begin
            tail_cnt_r <= tail_nxt_s;
         end else begin
            tail_cnt_r <= tail_cnt_r;
         end
         if (puncture_s) begin
            out_bits <= y_s;
            out_last <= load_tail_s & (tail_nxt_s == TAIL_LAST);
            state_r  <= load_tail_s ? ST_TAIL_Y : ST_SHOW_Y;
         end else begin
            out_bits <= x_s;
            out_last <= 1'b0;
            state_r  <= load_tail_s ? ST_TAIL_X : ST_SHOW_X;
         end
      end else begin
         case (state_r)
            ST_SHOW_X: begin
               out_bits <= y_hold_r;
               state_r  <= ST_SHOW_Y;
            end
            ST_TAIL_X: begin
               out_bits <= y_hold_r;
               out_last <= (tail_cnt_r == TAIL_LAST);
               state_r  <= ST_TAIL_Y;
            end
            ST_TAIL_Y: begin
               // Tail complete: next frame starts from the zero state.
               state_r    <= ST_IDLE;
               hist_r     <= 6'd0;
               tail_cnt_r <= 3'd0;
               out_bits   <= 1'b0;
               out_valid  <= 1'b0;
               out_last   <= 1'b0;
            end
            ST_IDLE, ST_SHOW_Y: begin
               // Upstream starved: pause output, history kept mid-frame.
               state_r   <= ST_IDLE;
               out_bits  <= 1'b0;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
            end
            default: begin
               state_r    <= ST_IDLE;
               hist_r     <= 6'd0;
               last_r     <= 1'b0;
               tail_cnt_r <= 3'd0;
               out_bits   <= 1'b0;
               out_valid  <= 1'b0;
               out_last   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_encoder.sv
// ---------------------------------------------------------------------------
// tb_conv_encoder -- directed self-checking bench for conv_encoder.
// Expected coded streams are hand-computed constants (MSB = first bit out).
// ---------------------------------------------------------------------------
module tb_conv_encoder;

   logic clk      = 1'b0;
   logic reset    = 1'b1;
   logic in_bits  = 1'b0;
   logic in_valid = 1'b0;
   logic in_last  = 1'b0;
   logic in_ready;
   logic out_bits;
   logic out_valid;
   logic out_last;
`ifdef CONV_PUNCTURE_EN
   logic rate_sel = 1'b0;
`endif

   int total  = 0;
   int bad    = 0;
   int n_last = 0;
   logic bit_q[$];
   logic last_q[$];

   always #5 clk = ~clk;

   conv_encoder dut (
      .clk       (clk),
      .reset     (reset),
      .in_bits   (in_bits),
      .in_valid  (in_valid),
      .in_last   (in_last),
`ifdef CONV_PUNCTURE_EN
      .rate_sel  (rate_sel),
`endif
      .in_ready  (in_ready),
      .out_bits  (out_bits),
      .out_valid (out_valid),
      .out_last  (out_last)
   );

   // Record every valid coded bit, sampled away from the rising edge.
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         bit_q.push_back(out_bits);
         last_q.push_back(out_last);
         if (out_last === 1'b1) n_last++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offer one bit, wait (bounded) for in_ready, return after the accepting edge.
   task automatic send_bit(input logic b, input logic l);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_bits  = b;
      in_last  = l;
      while (in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Wait (bounded) for the frame's out_last; report gap cycles seen meanwhile.
   task automatic wait_last(input string tag, input int base_last, output int gaps);
      int n;
      n    = 0;
      gaps = 0;
      while (n_last == base_last && n < 200) begin
         @(negedge clk);
         #1;
         if (out_valid !== 1'b1) gaps++;
         n++;
      end
      chk(tag, n_last - base_last, 32'd1);
   endtask

   task automatic check_frame(input string tag, input int base,
                              input logic [31:0] exp, input int n);
      int got;
      got = bit_q.size() - base;
      chk({tag, "_len"}, got, n);
      for (int i = 0; i < n && i < got; i++) begin
         chk({tag, "_bit"}, {31'd0, bit_q[base + i]}, {31'd0, exp[n - 1 - i]});
         chk({tag, "_last"}, {31'd0, last_q[base + i]}, {31'd0, (i == n - 1)});
      end
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      #1;
      chk({tag, "_ov"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      int base;
      int bl;
      int gaps;
      int idx;
      logic [3:0] hold_bits;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_ov", {31'd0, out_valid}, 32'd0);
      chk("rst_bits", {31'd0, out_bits}, 32'd0);
      chk("rst_last", {31'd0, out_last}, 32'd0);

      // 8 zero bits, last on the 8th: 16 data + 12 tail coded zeros.
      base = bit_q.size();
      bl   = n_last;
      for (int i = 0; i < 8; i++) send_bit(1'b0, i == 7);
      wait_last("zero_end", bl, gaps);
      check_frame("zero", base, 32'h0, 28);
      check_idle("zero_idle");

      // Impulse response: 11 10 11 11 00 01 11.
      base = bit_q.size();
      bl   = n_last;
      send_bit(1'b1, 1'b1);
      wait_last("imp_end", bl, gaps);
      check_frame("imp", base, 32'b11101111000111, 14);
      check_idle("imp_idle");

      // in_valid held high across 4 bits (1,0,1,1): ready toggles, output gapless.
      hold_bits = 4'b1011;
      base = bit_q.size();
      bl   = n_last;
      idx  = 0;
      in_valid = 1'b1;
      in_bits  = hold_bits[3];
      in_last  = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("hold_rdy", {31'd0, in_ready}, {31'd0, (k % 2 == 0)});
         if (k > 0) chk("hold_ov", {31'd0, out_valid}, 32'd1);
         @(negedge clk);
         if (k % 2 == 0) begin
            idx++;
            if (idx < 4) begin
               in_bits = hold_bits[3 - idx];
               in_last = (idx == 3);
            end else begin
               in_valid = 1'b0;
               in_last  = 1'b0;
            end
         end
      end
      wait_last("hold_end", bl, gaps);
      chk("hold_gaps", gaps, 32'd0);
      check_frame("hold", base, 32'b11100010010100011011, 20);
      check_idle("hold_idle");

      // Reset while the first tail X is on the output.
      send_bit(1'b1, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("tail_ov", {31'd0, out_valid}, 32'd1);
      chk("tail_x", {31'd0, out_bits}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_ov", {31'd0, out_valid}, 32'd0);
      chk("midrst_rdy", {31'd0, in_ready}, 32'd1);
      base = bit_q.size();
      bl   = n_last;
      send_bit(1'b1, 1'b1);
      wait_last("imp2_end", bl, gaps);
      check_frame("imp2", base, 32'b11101111000111, 14);
      check_idle("imp2_idle");

`ifdef CONV_PUNCTURE_EN
      // Rate 2/3: data 1,0 -> 1,1,0 then punctured tail 1,1,1,0,0,1,1,1,0.
      rate_sel = 1'b1;
      base = bit_q.size();
      bl   = n_last;
      send_bit(1'b1, 1'b0);
      rate_sel = 1'b0;
      send_bit(1'b0, 1'b1);
      wait_last("punc_end", bl, gaps);
      check_frame("punc", base, 32'b110111001110, 12);
      check_idle("punc_idle");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
